sm3_inpt_arb: RTL and testbench

//  Message-level round-robin arbiter sharing the SM3 padding input among N_REQ message sources.
//  - Grants one requester for a whole message: from first beat up to and including the beat with
//    msg_inpt_lst, then re-arbitrates.
//  - Muxes the granted stream onto msg_inpt_*; returns msg_inpt_rdy only to the granted source.
//  - Keeps an owner-ID FIFO so each compression-done pulse is tagged with the owning requester.

---
 rtl/sm3_inpt_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_sm3_inpt_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_inpt_arb.sv
// ---------------------------------------------------------------------------
// sm3_inpt_arb
//   Message-level round-robin arbiter in front of the SM3 padding unit.
//   One requester owns the pad input from its first beat through its last
//   beat (req_lst), then the arbiter re-arbitrates.  Every grant pushes the
//   owner's index into a small FIFO.  Each cmprss_done pulse pops that FIFO,
//   so finished digests come back tagged with the requester that sent them.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_d               per-requester beat data, slot i = [i*INPT_DW +: INPT_DW]
//   req_vld_byte        per-requester byte valids, slot i = [i*BYTE_DW +: BYTE_DW]
//   req_vld / req_lst   per-requester beat valid / last beat of message
//   req_rdy             per-requester ready (only the granted one can be high)
//   msg_inpt_*          muxed stream to the pad unit (d, vld_byte, vld, lst, rdy)
//   cmprss_done         one-cycle pulse per finished digest, in message order
//   rslt_id_vld/rslt_id owner tag of the finished digest, one cycle later
//   gnt_id              current or last granted requester
//   busy                a message transfer is in progress
//   err_undrflw         sticky: cmprss_done seen with no owner recorded
// ---------------------------------------------------------------------------
module sm3_inpt_arb #(
   parameter int N_REQ     = 2,
   parameter int INPT_DW   = 32,
   parameter int BYTE_DW   = 4,
   parameter int OWN_DEPTH = 4,
   localparam int ID_W     = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ*INPT_DW-1:0]   req_d,
   input  logic [N_REQ*BYTE_DW-1:0]   req_vld_byte,
   input  logic [N_REQ-1:0]           req_vld,
   input  logic [N_REQ-1:0]           req_lst,
   output logic [N_REQ-1:0]           req_rdy,
   output logic [INPT_DW-1:0]         msg_inpt_d,
   output logic [BYTE_DW-1:0]         msg_inpt_vld_byte,
   output logic                       msg_inpt_vld,
   output logic                       msg_inpt_lst,
   input  logic                       msg_inpt_rdy,
   input  logic                       cmprss_done,
   output logic                       rslt_id_vld,
   output logic [ID_W-1:0]            rslt_id,
   output logic [ID_W-1:0]            gnt_id,
   output logic                       busy,
   output logic                       err_undrflw
);

   localparam int PTR_W = $clog2(OWN_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
   logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;

   // round-robin search result
   logic [ID_W-1:0]   pick_id;
   logic              pick_vld;
   int                srch_idx;

   // granted slot, selected only by in-range indices so unused codes give 0
   logic [INPT_DW-1:0] slot_d;
   logic [BYTE_DW-1:0] slot_vld_byte;
   logic               slot_vld;
   logic               slot_lst;

   // owner FIFO
   logic [ID_W-1:0]   own_mem [OWN_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              fifo_full, fifo_empty;
   logic              grant, push, pop, bypass, wr_en, undrflw;
   logic              lst_acc;

   logic              rslt_id_vld_reg;
   logic [ID_W-1:0]   rslt_id_reg;
   logic              err_undrflw_reg;

   assign fifo_full  = (cnt_reg == CNT_W'(OWN_DEPTH));
   assign fifo_empty = (cnt_reg == '0);

   // first requesting index at or after rr_ptr_reg, wrapping modulo N_REQ
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      srch_idx = 0;
      for (int k = 0; k < N_REQ; k++) begin
         srch_idx = int'(rr_ptr_reg) + k;
         if (srch_idx >= N_REQ) begin
            srch_idx = srch_idx - N_REQ;
         end
         if (!pick_vld && req_vld[srch_idx]) begin
            pick_vld = 1'b1;
            pick_id  = ID_W'(srch_idx);
         end
      end
   end

   always_comb begin
      slot_d        = '0;
      slot_vld_byte = '0;
      slot_vld      = 1'b0;
      slot_lst      = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id_reg == ID_W'(i)) begin
            slot_d        = req_d[i*INPT_DW +: INPT_DW];
            slot_vld_byte = req_vld_byte[i*BYTE_DW +: BYTE_DW];
            slot_vld      = req_vld[i];
            slot_lst      = req_lst[i];
         end
      end
   end

   assign grant   = (state_reg == S_IDLE) && pick_vld && !fifo_full;
   assign lst_acc = (state_reg == S_XFER) && slot_vld && slot_lst && msg_inpt_rdy;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         gnt_id_reg <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         gnt_id_reg <= gnt_id_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next  = state_reg;
      gnt_id_next = gnt_id_reg;
      rr_ptr_next = rr_ptr_reg;
      case (state_reg)
         S_IDLE: begin
            if (grant) begin
               gnt_id_next = pick_id;
               state_next  = S_XFER;
            end
         end
         S_XFER: begin
            if (lst_acc) begin
               rr_ptr_next = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The idle cycle between messages is a deliberate arbitration bubble.
   always_comb begin
      msg_inpt_d        = '0;
      msg_inpt_vld_byte = '0;
      msg_inpt_vld      = 1'b0;
      msg_inpt_lst      = 1'b0;
      req_rdy           = '0;
      busy              = 1'b0;
      if (state_reg == S_XFER) begin
         busy              = 1'b1;
         msg_inpt_d        = slot_d;
         msg_inpt_vld_byte = slot_vld_byte;
         msg_inpt_vld      = slot_vld;
         msg_inpt_lst      = slot_lst;
         for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = msg_inpt_rdy && (gnt_id_reg == ID_W'(i));
         end
      end
   end

   // ---------------- owner FIFO ----------------
   // A pop against an empty FIFO that is being pushed in the same cycle
   // hands the new ID straight through; memory and pointers stay untouched.
   assign push    = grant;
   assign bypass  = cmprss_done && push && fifo_empty;
   assign pop     = cmprss_done && !fifo_empty;
   assign wr_en   = push && !bypass;
   assign undrflw = cmprss_done && fifo_empty && !push;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         own_mem[wr_ptr_reg] <= pick_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         cnt_reg         <= '0;
         rslt_id_vld_reg <= 1'b0;
         rslt_id_reg     <= '0;
         err_undrflw_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
         rslt_id_vld_reg <= pop || bypass;
         if (pop) begin
            rslt_id_reg <= own_mem[rd_ptr_reg];
         end else if (bypass) begin
            rslt_id_reg <= pick_id;
         end
         if (undrflw) begin
            err_undrflw_reg <= 1'b1;
         end
      end
   end

   assign rslt_id_vld = rslt_id_vld_reg;
   assign rslt_id     = rslt_id_reg;
   assign gnt_id      = gnt_id_reg;
   assign err_undrflw = err_undrflw_reg;

endmodule

// File: tb/tb_sm3_inpt_arb.sv
// ---------------------------------------------------------------------------
// tb_sm3_inpt_arb
//   Directed scenarios (reset, underflow, same-cycle push/pop, single message,
//   reset mid-message, owner FIFO full) followed by randomized traffic from
//   two message sources, checked against a transaction-level reference model
//   (round-robin owner choice, per-owner message/beat order, owner queue).
// ---------------------------------------------------------------------------
module tb_sm3_inpt_arb;

   localparam int N_REQ     = 2;
   localparam int INPT_DW   = 32;
   localparam int BYTE_DW   = 4;
   localparam int OWN_DEPTH = 4;
   localparam int ID_W      = 1;
   localparam int NMSG      = 6;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [N_REQ*INPT_DW-1:0] req_d = '0;
   logic [N_REQ*BYTE_DW-1:0] req_vld_byte = '0;
   logic [N_REQ-1:0]         req_vld = '0;
   logic [N_REQ-1:0]         req_lst = '0;
   logic [N_REQ-1:0]         req_rdy;
   logic [INPT_DW-1:0]       msg_inpt_d;
   logic [BYTE_DW-1:0]       msg_inpt_vld_byte;
   logic                     msg_inpt_vld;
   logic                     msg_inpt_lst;
   logic                     msg_inpt_rdy = 1'b0;
   logic                     cmprss_done = 1'b0;
   logic                     rslt_id_vld;
   logic [ID_W-1:0]          rslt_id;
   logic [ID_W-1:0]          gnt_id;
   logic                     busy;
   logic                     err_undrflw;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sm3_inpt_arb #(
      .N_REQ     (N_REQ),
      .INPT_DW   (INPT_DW),
      .BYTE_DW   (BYTE_DW),
      .OWN_DEPTH (OWN_DEPTH)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_d             (req_d),
      .req_vld_byte      (req_vld_byte),
      .req_vld           (req_vld),
      .req_lst           (req_lst),
      .req_rdy           (req_rdy),
      .msg_inpt_d        (msg_inpt_d),
      .msg_inpt_vld_byte (msg_inpt_vld_byte),
      .msg_inpt_vld      (msg_inpt_vld),
      .msg_inpt_lst      (msg_inpt_lst),
      .msg_inpt_rdy      (msg_inpt_rdy),
      .cmprss_done       (cmprss_done),
      .rslt_id_vld       (rslt_id_vld),
      .rslt_id           (rslt_id),
      .gnt_id            (gnt_id),
      .busy              (busy),
      .err_undrflw       (err_undrflw)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] beat_data(input int i, input int m, input int b);
      return {8'(i), 8'(m), 8'(b), 8'(i*37 + m*11 + b*3 + 90)};
   endfunction

   function automatic logic [3:0] beat_be(input int m, input bit last);
      if (!last) return 4'hF;
      case (m % 4)
         0:       return 4'hF;
         1:       return 4'h7;
         2:       return 4'h3;
         default: return 4'h1;
      endcase
   endfunction

   task automatic set_slot(input int i, input logic [31:0] d, input logic [3:0] be,
                           input logic v, input logic l);
      req_d[i*INPT_DW +: INPT_DW]        = d;
      req_vld_byte[i*BYTE_DW +: BYTE_DW] = be;
      req_vld[i]                         = v;
      req_lst[i]                         = l;
   endtask

   // drive point: just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sample point: falling edge
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req_d        = '0;
      req_vld_byte = '0;
      req_vld      = '0;
      req_lst      = '0;
      msg_inpt_rdy = 1'b0;
      cmprss_done  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // random-phase state
   int  len_tbl [N_REQ][NMSG];
   int  d_msg [N_REQ];
   int  d_beat [N_REQ];
   bit  acc [N_REQ];
   int  m_done [N_REQ];
   int  cur_owner, out_beat, rr, exp_own, grants, j;
   int  own_q [$];
   bit  busy_prev, done_prev, pend_rslt, finished, last_b;

   initial begin
      // ---------------- reset state ----------------
      clear_inputs();
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_vld", msg_inpt_vld, 0);
      chk("rst_rdy", req_rdy, 0);
      chk("rst_gnt", gnt_id, 0);
      chk("rst_rslt_vld", rslt_id_vld, 0);
      chk("rst_err", err_undrflw, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- underflow with no grant ----------------
      cmprss_done = 1'b1;
      tick();
      cmprss_done = 1'b0;
      smp();
      chk("undrflw_rslt_vld", rslt_id_vld, 0);
      chk("undrflw_err", err_undrflw, 1);
      do_reset();
      smp();
      chk("err_cleared", err_undrflw, 0);
      tick();

      // ---------------- done in the grant cycle, empty FIFO ----------------
      set_slot(1, beat_data(1, 9, 0), 4'hF, 1'b1, 1'b1);
      msg_inpt_rdy = 1'b1;
      cmprss_done  = 1'b1;
      tick();
      cmprss_done = 1'b0;
      smp();
      chk("byp_rslt_vld", rslt_id_vld, 1);
      chk("byp_rslt_id", rslt_id, 1);
      chk("byp_err", err_undrflw, 0);
      chk("byp_gnt", gnt_id, 1);
      chk("byp_data", msg_inpt_d, beat_data(1, 9, 0));
      chk("byp_rdy", req_rdy, 2'b10);
      tick();
      set_slot(1, '0, '0, 1'b0, 1'b0);
      smp();
      chk("byp_idle", busy, 0);
      tick();
      cmprss_done = 1'b1;
      tick();
      cmprss_done = 1'b0;
      smp();
      chk("byp_then_undrflw", err_undrflw, 1);
      chk("byp_then_no_rslt", rslt_id_vld, 0);
      do_reset();

      // ---------------- single 3-beat message from req0 ----------------
      set_slot(0, beat_data(0, 0, 0), 4'hF, 1'b1, 1'b0);
      msg_inpt_rdy = 1'b1;
      smp();
      chk("bubble_busy", busy, 0);
      chk("bubble_vld", msg_inpt_vld, 0);
      tick();
      for (int b = 0; b < 3; b++) begin
         smp();
         chk("m1_vld", msg_inpt_vld, 1);
         chk("m1_data", msg_inpt_d, beat_data(0, 0, b));
         chk("m1_lst", msg_inpt_lst, (b == 2));
         chk("m1_gnt", gnt_id, 0);
         tick();
         if (b < 2) set_slot(0, beat_data(0, 0, b+1), 4'hF, 1'b1, (b+1 == 2));
         else       set_slot(0, '0, '0, 1'b0, 1'b0);
      end
      smp();
      chk("m1_done_idle", busy, 0);
      tick();
      cmprss_done = 1'b1;
      tick();
      cmprss_done = 1'b0;
      smp();
      chk("m1_rslt_vld", rslt_id_vld, 1);
      chk("m1_rslt_id", rslt_id, 0);
      tick();

      // ---------------- reset during beat 2 of req1 message ----------------
      set_slot(1, beat_data(1, 0, 0), 4'hF, 1'b1, 1'b0);
      tick();
      smp();
      chk("abort_gnt", gnt_id, 1);
      tick();
      set_slot(1, beat_data(1, 0, 1), 4'hF, 1'b1, 1'b0);
      smp();
      chk("abort_beat2", msg_inpt_d, beat_data(1, 0, 1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_vld", msg_inpt_vld, 0);
      chk("abort_d", msg_inpt_d, 0);
      chk("abort_rdy", req_rdy, 0);
      chk("abort_gnt0", gnt_id, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_slot(0, beat_data(0, 0, 0), 4'hF, 1'b1, 1'b1);
      set_slot(1, beat_data(1, 0, 0), 4'hF, 1'b1, 1'b1);
      tick();
      smp();
      chk("post_rst_busy", busy, 1);
      chk("post_rst_gnt", gnt_id, 0);
      do_reset();

      // ---------------- owner FIFO full blocks grants ----------------
      set_slot(0, beat_data(0, 0, 0), 4'hF, 1'b1, 1'b1);
      msg_inpt_rdy = 1'b1;
      grants    = 0;
      busy_prev = 1'b0;
      for (int c = 0; c < 16; c++) begin
         smp();
         if (busy && !busy_prev) grants++;
         busy_prev = busy;
         tick();
      end
      chk("full_grants", grants, OWN_DEPTH);
      smp();
      chk("full_busy", busy, 0);
      chk("full_rdy", req_rdy, 0);
      tick();
      cmprss_done = 1'b1;
      tick();
      cmprss_done = 1'b0;
      smp();
      chk("full_pop_vld", rslt_id_vld, 1);
      chk("full_pop_id", rslt_id, 0);
      chk("full_pop_busy", busy, 0);
      tick();
      smp();
      chk("full_regrant", busy, 1);
      do_reset();

      // ---------------- randomized traffic vs reference model ----------------
      for (int i = 0; i < N_REQ; i++) begin
         d_msg[i]  = 0;
         d_beat[i] = 0;
         acc[i]    = 1'b0;
         m_done[i] = 0;
         for (int m = 0; m < NMSG; m++) len_tbl[i][m] = $urandom_range(1, 4);
      end
      cur_owner = 0;
      out_beat  = 0;
      rr        = 0;
      busy_prev = 1'b0;
      done_prev = 1'b0;
      pend_rslt = 1'b0;
      finished  = 1'b0;
      own_q.delete();

      for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
         // drive sources from their own message state
         for (int i = 0; i < N_REQ; i++) begin
            if (acc[i]) begin
               if (d_beat[i] == len_tbl[i][d_msg[i]] - 1) begin
                  d_msg[i]++;
                  d_beat[i] = 0;
               end else begin
                  d_beat[i]++;
               end
            end
            if (d_msg[i] < NMSG) begin
               last_b = (d_beat[i] == len_tbl[i][d_msg[i]] - 1);
               set_slot(i, beat_data(i, d_msg[i], d_beat[i]), beat_be(d_msg[i], last_b),
                        (d_beat[i] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0), last_b);
            end else begin
               set_slot(i, '0, '0, 1'b0, 1'b0);
            end
         end
         msg_inpt_rdy = ($urandom_range(0, 3) != 0);
         cmprss_done  = (own_q.size() > 0) && !done_prev && ($urandom_range(0, 2) == 0);
         done_prev    = cmprss_done;

         smp();
         if (pend_rslt) begin
            chk("rnd_rslt_vld", rslt_id_vld, 1);
            if (own_q.size() > 0) chk("rnd_rslt_id", rslt_id, own_q.pop_front());
         end else begin
            chk("rnd_no_rslt", rslt_id_vld, 0);
         end
         pend_rslt = cmprss_done;

         if (busy && !busy_prev) begin
            exp_own = -1;
            for (int k = 0; k < N_REQ; k++) begin
               j = (rr + k) % N_REQ;
               if (exp_own < 0 && m_done[j] < NMSG) exp_own = j;
            end
            chk("rnd_gnt", gnt_id, exp_own);
            cur_owner = (exp_own < 0) ? 0 : exp_own;
            own_q.push_back(cur_owner);
            out_beat = 0;
         end

         if (busy) chk("rnd_rdy", req_rdy, msg_inpt_rdy ? (1 << cur_owner) : 0);
         else      chk("rnd_rdy_idle", req_rdy, 0);

         if (msg_inpt_vld && msg_inpt_rdy && m_done[cur_owner] < NMSG) begin
            last_b = (out_beat == len_tbl[cur_owner][m_done[cur_owner]] - 1);
            chk("rnd_data", msg_inpt_d, beat_data(cur_owner, m_done[cur_owner], out_beat));
            chk("rnd_be", msg_inpt_vld_byte, beat_be(m_done[cur_owner], last_b));
            chk("rnd_lst", msg_inpt_lst, last_b);
            if (last_b) begin
               m_done[cur_owner]++;
               rr = (cur_owner + 1) % N_REQ;
            end else begin
               out_beat++;
            end
         end

         for (int i = 0; i < N_REQ; i++) acc[i] = req_vld[i] && req_rdy[i];
         busy_prev = busy;

         finished = 1'b1;
         for (int i = 0; i < N_REQ; i++) if (m_done[i] < NMSG) finished = 1'b0;
         if (own_q.size() > 0 || pend_rslt) finished = 1'b0;
         tick();
      end
      chk("rnd_completed", finished, 1);
      smp();
      chk("rnd_err", err_undrflw, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
